// File: rtl/relu_maxpool_stream.sv
// relu_maxpool_stream
//   Streaming 2x2 / stride-2 max-pool that follows the convolution adder tree.
//   Samples arrive one per in_valid beat in raster order over a MAP_W x MAP_H
//   map. Each odd-column beat reduces a horizontal pair. Even rows park that
//   pair maximum in a line buffer, and odd rows combine it with the stored
//   value and emit one pooled result on the following clock.
//   Odd map dimensions follow floor semantics: the trailing column or row is
//   counted but never pooled.
//
//   Optional build macro RELU_POOL_EN: clamps negative pooled results to zero
//   (ReLU after pooling). Latency is the same either way.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   frame_start  one-cycle pulse, restarts counters at (0,0); a coincident
//                sample is treated as (0,0)
//   in_valid     input sample strobe
//   in_data      signed DW-bit sample
//   out_valid    one-cycle pulse, pooled sample valid
//   out_data     signed pooled sample
//   out_row      pooled row index
//   out_col      pooled column index
//   frame_done   pulses with the last pooled output of a frame
module relu_maxpool_stream #(
    parameter int MAP_W = 26,
    parameter int MAP_H = 26,
    parameter int DW    = 8,
    localparam int RW   = (MAP_H / 2 > 1) ? $clog2(MAP_H / 2) : 1,
    localparam int CLW  = (MAP_W / 2 > 1) ? $clog2(MAP_W / 2) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_start,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] in_data,
    output logic                 out_valid,
    output logic signed [DW-1:0] out_data,
    output logic [RW-1:0]        out_row,
    output logic [CLW-1:0]       out_col,
    output logic                 frame_done
);
    localparam int CW    = $clog2(MAP_W);
    localparam int RC    = $clog2(MAP_H);
    localparam bit ODD_H = (MAP_H % 2) == 1;

    logic [CW-1:0]        col, eff_col;
    logic [RC-1:0]        row, eff_row;
    logic signed [DW-1:0] pair, pmax, lb_rd, wmax, res;
    logic signed [DW-1:0] line_buf [MAP_W/2];
    logic [CLW-1:0]       lb_idx;
    logic [RW-1:0]        prow;
    logic                 lb_we, produce, last_win;

    always_comb begin
        // frame_start overrides the counters in the same cycle so that a
        // coincident sample lands at (0,0) of the new frame.
        eff_col  = frame_start ? '0 : col;
        eff_row  = frame_start ? '0 : row;
        lb_idx   = CLW'(eff_col >> 1);
        prow     = RW'(eff_row >> 1);
        pmax     = (in_data > pair) ? in_data : pair;
        lb_rd    = line_buf[lb_idx];
        wmax     = (lb_rd > pmax) ? lb_rd : pmax;
        // The unpaired last row of an odd-height map never enters the buffer.
        lb_we    = in_valid && eff_col[0] && !eff_row[0]
                   && !(ODD_H && (eff_row == RC'(MAP_H - 1)));
        produce  = in_valid && eff_col[0] && eff_row[0];
        last_win = (prow == RW'(MAP_H / 2 - 1)) && (lb_idx == CLW'(MAP_W / 2 - 1));
`ifdef RELU_POOL_EN
        res      = wmax[DW-1] ? '0 : wmax;
`else
        res      = wmax;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col  <= '0;
            row  <= '0;
            pair <= '0;
        end else if (in_valid) begin
            if (!eff_col[0]) begin
                pair <= in_data;
            end
            if (eff_col == CW'(MAP_W - 1)) begin
                col <= '0;
                row <= (eff_row == RC'(MAP_H - 1)) ? '0 : eff_row + RC'(1);
            end else begin
                col <= eff_col + CW'(1);
                row <= eff_row;
            end
        end else if (frame_start) begin
            col  <= '0;
            row  <= '0;
            pair <= '0;
        end
    end

    // Writes happen only on even rows and reads only on odd rows, so the
    // same entry is never read and written in one cycle.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            line_buf[lb_idx] <= pmax;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_row    <= '0;
            out_col    <= '0;
            frame_done <= 1'b0;
        end else begin
            out_valid  <= produce;
            frame_done <= produce && last_win;
            if (produce) begin
                out_data <= res;
                out_row  <= prow;
                out_col  <= lb_idx;
            end
        end
    end

endmodule
